// File: rtl/cpu_pkg.sv
// Shared encodings for the 5-stage pipeline control blocks.
package cpu_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_e;

    localparam logic [5:0] OPC_HALT = 6'b111111;

    // A later stage's register-file write port, as seen by the forwarding logic.
    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
    } wr_port_t;

    function automatic logic is_halt_opc(input logic [5:0] opc);
        return opc == OPC_HALT;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX operand source select for one ALU input; MEM result is newer than WB so it wins.
module fwd_unit
    import cpu_pkg::*;
(
    input  logic [4:0] src,
    input  wr_port_t   mem,
    input  wr_port_t   wb,
    output fwd_sel_e   sel
);

    always_comb begin
        sel = FWD_RF;
        if (wb.reg_write && wb.rd != 5'd0 && wb.rd == src)
            sel = FWD_WB;
        if (mem.reg_write && mem.rd != 5'd0 && mem.rd == src)
            sel = FWD_MEM;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control: load-use stall, branch/jump flush, EX forwarding,
// halt drain with sticky halted flag, and saturating stall/flush counters.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_halt,
    input  logic             id_jump,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e         state;
    logic [DCW-1:0] drain_cnt;

    wr_port_t mem_wr, wb_wr;
    fwd_sel_e fwd_a_raw, fwd_b_raw;
    logic     load_use;
    logic     cnt_stall, cnt_flush, go_drain;

    // The hazard unit only looks at the load opcode; write-enable is implied.
    logic unused_ex_reg_write;
    assign unused_ex_reg_write = ex_reg_write;

    assign mem_wr.rd        = mem_rd;
    assign mem_wr.reg_write = mem_reg_write;
    assign wb_wr.rd         = wb_rd;
    assign wb_wr.reg_write  = wb_reg_write;

    fwd_unit u_fwd_a (
        .src (ex_rs),
        .mem (mem_wr),
        .wb  (wb_wr),
        .sel (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .src (ex_rt),
        .mem (mem_wr),
        .wb  (wb_wr),
        .sel (fwd_b_raw)
    );

    assign fwd_a = Rst ? FWD_RF : fwd_a_raw;
    assign fwd_b = Rst ? FWD_RF : fwd_b_raw;

    assign load_use = id_valid && ex_mem_read && ex_rd != 5'd0 &&
                      ((id_uses_rs && id_rs == ex_rd) ||
                       (id_uses_rt && id_rt == ex_rd));

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        cnt_stall  = 1'b0;
        cnt_flush  = 1'b0;
        go_drain   = 1'b0;
        if (Rst || state != RUN) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (ex_branch_taken) begin
            // Everything younger than the branch is wrong-path, including ID hazards.
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            cnt_flush  = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            cnt_stall  = 1'b1;
        end else if (id_halt && id_valid) begin
            // Halt proceeds into EX; nothing behind it is fetched.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            go_drain   = 1'b1;
        end else if (id_jump && id_valid) begin
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            cnt_flush  = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (cnt_stall && !(&stall_cnt))
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    if (cnt_flush && !(&flush_cnt))
                        flush_cnt <= flush_cnt + CNT_W'(1);
                    if (go_drain) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DCW'(DRAIN_CYCLES - 1)) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                HALTED: halted <= 1'b1;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle-level reference model checked every
// cycle, plus literal expectations attached to specific vectors.
module tb_pipe_hazard_ctrl;

    localparam int D = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       id_valid, id_uses_rs, id_uses_rt, id_halt, id_jump;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       ex_reg_write, ex_mem_read, ex_branch_taken, mem_reg_write, wb_reg_write;

    logic        pc_en, ifid_en, ifid_flush, idex_flush, halted;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush, s_halted;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(D), .CNT_W(16)) u_dut (
        .Clk(clk), .Rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_halt(id_halt), .id_jump(id_jump),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.DRAIN_CYCLES(D), .CNT_W(2)) u_sat (
        .Clk(clk), .Rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_halt(id_halt), .id_jump(id_jump),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // ---------------- reference model ----------------
    // age: 0 = running, 1..D = drain cycle number, >D = halted
    int ready = 0;
    int age   = 0;
    int m_st  = 0;
    int m_fl  = 0;

    function automatic logic m_load_use();
        return id_valid && ex_mem_read && ex_rd != 0 &&
               ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    endfunction

    function automatic int m_fwd(input logic [4:0] s);
        if (mem_reg_write && mem_rd != 0 && mem_rd == s) return 2;
        if (wb_reg_write && wb_rd != 0 && wb_rd == s) return 1;
        return 0;
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ready <= 1;
            age   <= 0;
            m_st  <= 0;
            m_fl  <= 0;
        end else if (ready != 0) begin
            if (age == 0) begin
                if (ex_branch_taken)             m_fl <= m_fl + 1;
                else if (m_load_use())           m_st <= m_st + 1;
                else if (id_halt && id_valid)    age  <= 1;
                else if (id_jump && id_valid)    m_fl <= m_fl + 1;
            end else if (age <= D) begin
                age <= age + 1;
            end
        end
    end

    // ---------------- literal expectations from the stimulus ----------------
    int    lit_n = 0;
    int    lit_sel [8];
    int    lit_val [8];
    string lit_name[8];

    task automatic lit(input string n, input int sel, input int v);
        lit_name[lit_n] = n;
        lit_sel[lit_n]  = sel;
        lit_val[lit_n]  = v;
        lit_n++;
    endtask

    function automatic int act(input int sel);
        case (sel)
            0: return int'(pc_en);
            1: return int'(ifid_en);
            2: return int'(ifid_flush);
            3: return int'(idex_flush);
            4: return int'(fwd_a);
            5: return int'(fwd_b);
            6: return int'(halted);
            7: return int'(stall_cnt);
            8: return int'(flush_cnt);
            9: return int'(s_stall_cnt);
            default: return -1;
        endcase
    endfunction

    // ---------------- compare process ----------------
    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string n, input int a, input int e);
        n_tot++;
        if (a == e) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", n, a, e, $time);
    endtask

    always @(negedge clk) begin
        int e_pc, e_ife, e_iff, e_idf, e_fa, e_fb;
        if (ready != 0) begin
            e_fa = m_fwd(ex_rs);
            e_fb = m_fwd(ex_rt);
            e_ife = -1;
            if (rst) begin
                e_pc = 0; e_ife = 0; e_iff = 1; e_idf = 1; e_fa = 0; e_fb = 0;
            end else if (age > 0) begin
                e_pc = 0; e_ife = 0; e_iff = 1; e_idf = 1;
            end else if (ex_branch_taken) begin
                e_pc = 1; e_iff = 1; e_idf = 1;
            end else if (m_load_use()) begin
                e_pc = 0; e_ife = 0; e_iff = 0; e_idf = 1;
            end else if (id_halt && id_valid) begin
                e_pc = 0; e_iff = 1; e_idf = 0;
            end else if (id_jump && id_valid) begin
                e_pc = 1; e_iff = 1; e_idf = 0;
            end else begin
                e_pc = 1; e_ife = 1; e_iff = 0; e_idf = 0;
            end
            chk("pc_en", int'(pc_en), e_pc);
            if (e_ife >= 0) chk("ifid_en", int'(ifid_en), e_ife);
            chk("ifid_flush", int'(ifid_flush), e_iff);
            chk("idex_flush", int'(idex_flush), e_idf);
            chk("fwd_a", int'(fwd_a), e_fa);
            chk("fwd_b", int'(fwd_b), e_fb);
            chk("halted", int'(halted), (age > D) ? 1 : 0);
            chk("stall_cnt", int'(stall_cnt), sat(m_st, 16));
            chk("flush_cnt", int'(flush_cnt), sat(m_fl, 16));
            chk("sat_stall_cnt", int'(s_stall_cnt), sat(m_st, 2));
            chk("sat_flush_cnt", int'(s_flush_cnt), sat(m_fl, 2));
            chk("sat_halted", int'(s_halted), (age > D) ? 1 : 0);
        end
        for (int i = 0; i < lit_n; i++)
            chk(lit_name[i], act(lit_sel[i]), lit_val[i]);
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_halt = 0; id_jump = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_branch_taken = 0;
        mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        lit_n = 0;
    endtask

    task automatic lw_dep();
        id_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 8; id_rt = 8; id_uses_rt = 1;
    endtask

    int sat_seq[4] = '{1, 2, 3, 3};

    initial begin
        idle();
        rst = 1;
        lit("rst_pc_en", 0, 0); lit("rst_ifid_en", 1, 0);
        lit("rst_ifid_flush", 2, 1); lit("rst_idex_flush", 3, 1);
        cyc();
        cyc();
        rst = 0;
        lit("post_rst_halted", 6, 0); lit("post_rst_stall", 7, 0);
        lit("post_rst_flush", 8, 0); lit("run_pc_en", 0, 1);
        cyc();

        // forwarding priority and $0
        ex_rs = 5; mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
        lit("fwd_mem_pri", 4, 2); cyc();
        mem_reg_write = 0; lit("fwd_wb", 4, 1); cyc();
        mem_reg_write = 1; mem_rd = 0; wb_rd = 0; ex_rs = 0; lit("fwd_r0", 4, 0); cyc();
        ex_rs = 5; ex_rt = 7; mem_rd = 7; wb_rd = 5;
        lit("fwd_b_mem", 5, 2); lit("fwd_a_wb", 4, 1); cyc();
        idle();

        // load-use stall for one cycle
        lw_dep();
        lit("lu_pc_en", 0, 0); lit("lu_ifid_en", 1, 0); lit("lu_idex_flush", 3, 1); cyc();
        ex_mem_read = 0;
        lit("after_lu_pc_en", 0, 1); lit("after_lu_idex_flush", 3, 0); lit("stall_1", 7, 1); cyc();
        // no stall: source not read, or load to $0
        ex_mem_read = 1; id_uses_rt = 0; id_rs = 8; lit("lu_unused_pc_en", 0, 1); cyc();
        id_uses_rt = 1; ex_rd = 0; id_rt = 0; lit("lu_r0_pc_en", 0, 1); cyc();
        idle();

        // branch beats load-use
        lw_dep(); ex_branch_taken = 1;
        lit("br_pc_en", 0, 1); lit("br_ifid_flush", 2, 1); lit("br_idex_flush", 3, 1); cyc();
        idle(); lit("br_stall_kept", 7, 1); lit("br_flush_1", 8, 1); cyc();

        // jump
        id_valid = 1; id_jump = 1;
        lit("j_pc_en", 0, 1); lit("j_ifid_flush", 2, 1); lit("j_idex_flush", 3, 0); cyc();
        id_valid = 0; lit("j_flush_2", 8, 2); lit("j_invalid_no_flush", 2, 0); cyc();
        idle();

        // halt and drain
        id_valid = 1; id_halt = 1;
        lit("h_pc_en", 0, 0); lit("h_ifid_flush", 2, 1); lit("h_idex_flush", 3, 0); cyc();
        idle(); ex_rs = 3; mem_rd = 3; mem_reg_write = 1;
        lit("d1_fwd_a", 4, 2); lit("d1_pc_en", 0, 0); lit("d1_halted", 6, 0); cyc();
        idle(); ex_branch_taken = 1;
        lit("d2_br_pc_en", 0, 0); lit("d2_halted", 6, 0); cyc();
        idle(); lit("d3_halted", 6, 0); lit("d3_flush_kept", 8, 2); cyc();
        for (int i = 0; i < 21; i++) begin
            if (i == 5) begin id_valid = 1; id_jump = 1; end
            if (i == 6) idle();
            lit("halted_sticky", 6, 1); lit("halted_pc_en", 0, 0);
            cyc();
        end
        lit("halted_flush_kept", 8, 2);
        rst = 1; cyc();
        rst = 0; cyc();

        // reset in the second drain cycle
        id_valid = 1; id_halt = 1; cyc();
        idle(); cyc();
        rst = 1; ex_rs = 5; mem_rd = 5; mem_reg_write = 1;
        lit("mrst_pc_en", 0, 0); lit("mrst_ifid_flush", 2, 1);
        lit("mrst_idex_flush", 3, 1); lit("mrst_fwd_a", 4, 0); cyc();
        idle(); rst = 0;
        lit("mrst_halted", 6, 0); lit("mrst_stall", 7, 0);
        lit("mrst_flush", 8, 0); lit("mrst_run_pc_en", 0, 1); cyc();

        // five back-to-back load-use stalls; 2-bit counter saturates at 3
        lw_dep(); lit("sat_start", 9, 0); cyc();
        for (int k = 0; k < 4; k++) begin
            lit("sat_seq", 9, sat_seq[k]);
            cyc();
        end
        idle(); lit("sat_final", 9, 3); lit("wide_stall_5", 7, 5); cyc();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It sits beside the decoder and pipeline registers. It detects load-use hazards and stalls, flushes on taken branch/jump, and selects EX-stage operand forwarding. It also drains the pipeline on a halt instruction before asserting a sticky halted flag, and keeps saturating stall/flush performance counters.

Parameters:
DRAIN_CYCLES, 3, cycles spent in DRAIN after halt leaves ID (EX, MEM, WB retire)
CNT_W, 16, width of stall/flush performance counters

Ports:
Clk  in  1  system clock, all state on posedge
Rst  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  5  ID rs field
id_rt  in  5  ID rt field
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_halt  in  1  ID instruction is halt (opcode 6'b111111)
id_jump  in  1  ID instruction is j
ex_rs  in  5  EX source register A
ex_rt  in  5  EX source register B
ex_rd  in  5  EX destination register, after Reg_Dst mux
ex_reg_write  in  1  EX writes the register file
ex_mem_read  in  1  EX instruction is lw
ex_branch_taken  in  1  beq/bne resolved taken in EX
mem_rd  in  5  MEM destination register
mem_reg_write  in  1  MEM writes the register file
wb_rd  in  5  WB destination register
wb_reg_write  in  1  WB writes the register file
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID register load enable
ifid_flush  out  1  IF/ID register clear to bubble
idex_flush  out  1  ID/EX register clear to bubble
fwd_a  out  2  ALU A select: 00 regfile, 01 WB, 10 MEM
fwd_b  out  2  ALU B select, same encoding
halted  out  1  sticky; pipeline drained after halt
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  branch/jump flush events, saturating

Behaviour:
- Reset (Rst=1 at posedge): state=RUN, drain counter=0, halted=0, stall_cnt=0, flush_cnt=0.
- While Rst=1, combinational outputs are forced: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, fwd_a=fwd_b=00.
- Forwarding is combinational and applies in every state. fwd_a=10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs. Otherwise fwd_a=01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs. Otherwise 00. fwd_b is the same using ex_rt. MEM has priority over WB. Register $0 is never forwarded.
- load_use = id_valid && ex_mem_read && ex_rd!=0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)).
- Priority in RUN, highest first:
  1. ex_branch_taken: pc_en=1, ifid_flush=1, idex_flush=1. Any load_use, id_jump or id_halt this cycle is ignored because it is on the wrong path. flush_cnt increments.
  2. load_use: pc_en=0, ifid_en=0, idex_flush=1, for exactly one cycle; the lw then moves to MEM and the condition clears. stall_cnt increments.
  3. id_halt && id_valid: go to DRAIN with drain counter=0. This cycle: pc_en=0, ifid_flush=1. The halt itself enters EX.
  4. id_jump && id_valid: pc_en=1, ifid_flush=1. flush_cnt increments.
  5. Default: pc_en=1, ifid_en=1, both flushes 0.
- DRAIN: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1. Forwarding stays active so older instructions complete correctly. The counter increments each cycle. When it reaches DRAIN_CYCLES-1, go to HALTED.
- ex_branch_taken cannot occur in DRAIN because the halt is the youngest valid instruction; if it does occur, it is ignored.
- HALTED: halted=1, pc_en=0, ifid_en=0, both flushes 1. Only Rst leaves this state.
- Counters saturate at all-ones and never wrap.
- Reset mid-DRAIN returns to RUN with halted=0 on the next cycle.
- Latency: hazard outputs are combinational, same cycle as their inputs. halted rises DRAIN_CYCLES+1 cycles after the halt is in ID.

Decomposition:
- Shared package cpu_pkg: forwarding encodings FWD_RF/FWD_WB/FWD_MEM, state encodings RUN/DRAIN/HALTED, OPC_HALT=6'b111111.
- One natural sub-module: fwd_unit (pure combinational, instantiated twice, once for A and once for B).
- Everything else (FSM, hazard logic, counters) stays in this block.

Test Plan:
- Forwarding priority: ex_rs=5, mem_rd=5/mem_reg_write=1, wb_rd=5/wb_reg_write=1 -> fwd_a=10. Drop mem_reg_write -> fwd_a=01. Set mem_rd=wb_rd=0 -> fwd_a=00.
- Load-use: ex_mem_read=1, ex_rd=8, id_rt=8, id_uses_rt=1 -> one cycle of pc_en=0/ifid_en=0/idex_flush=1, stall_cnt 0->1. The next cycle (ex_mem_read=0) is normal.
- Branch overrides load-use: load_use and ex_branch_taken both asserted -> ifid_flush=idex_flush=1, pc_en=1, stall_cnt unchanged, flush_cnt+1.
- Halt drain: id_halt=1 with DRAIN_CYCLES=3 -> pc_en=0 from that cycle, halted=1 exactly 4 cycles later, and it stays 1 for 20 more cycles.
- Reset mid-DRAIN: Rst=1 one cycle during the second drain cycle -> all outputs forced, then RUN, halted=0, counters 0.
- Saturation: CNT_W=2, apply 5 load-use stalls -> stall_cnt sequence 1,2,3,3,3.
